uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FRQ, default 100, meaning clock frequency in arbitrary units.
REQ-002 The block SHALL have parameter BAUD_RATE, default 10, meaning line bit rate in the same units as CLK_FRQ.
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge, no derived clocks.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-009 The block SHALL have port tx_data, input, 8 bits: byte to send.
REQ-010 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-011 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have port done_tx, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-014 BAUD_DIV SHALL equal CLK_FRQ/BAUD_RATE using integer division; elaboration SHALL fail if BAUD_DIV<2, STOP_BITS is not 1 or 2, or any flag is not 0 or 1.
REQ-015 Every line bit SHALL be held on tx for exactly BAUD_DIV clk cycles.
REQ-016 A byte SHALL be accepted on the rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be captured into an internal shift register at that edge.
REQ-017 tx_ready SHALL be 1 only in IDLE and SHALL be 0 in every other state.
REQ-018 Once captured, the frame SHALL be unaffected by changes to tx_data or tx_valid.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-020 IDLE SHALL go to START on acceptance.
REQ-021 START SHALL go to DATA after BAUD_DIV cycles.
REQ-022 DATA SHALL go to PARITY after 8 bits if PARITY_EN=1, otherwise to STOP.
REQ-023 PARITY SHALL go to STOP after BAUD_DIV cycles.
REQ-024 STOP SHALL go to IDLE after STOP_BITS*BAUD_DIV cycles.
REQ-025 tx SHALL be registered: 1 in IDLE, 0 in START, the data bit in DATA (LSB first, bit 0 first), the parity bit in PARITY, and 1 in STOP.
REQ-026 The parity bit SHALL be the XOR of the 8 captured bits, inverted when PARITY_ODD=1.
REQ-027 Latency SHALL be as follows: the start bit appears on tx in the cycle after the accepting edge, and the baud counter SHALL restart at 0 on acceptance.
REQ-028 A full frame SHALL occupy (9+PARITY_EN+STOP_BITS)*BAUD_DIV cycles of busy=1.
REQ-029 done_tx SHALL be 1 for exactly the first IDLE cycle after STOP; tx_ready SHALL also be 1 in that cycle.
REQ-030 Back-to-back transfers SHALL be supported: a byte presented in the done_tx cycle SHALL be accepted, giving a minimum inter-frame gap of 1 clk.
REQ-031 The bit counter SHALL run 0..7 and SHALL return to 0 on leaving DATA.
REQ-032 The baud counter SHALL run 0..BAUD_DIV-1, wrap to 0 at each bit boundary, and be held at 0 in IDLE.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, tx=1, tx_ready=0, busy=0, done_tx=0, and all counters and the shift register are 0.
REQ-035 tx_ready SHALL rise in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, no done_tx pulse, and the byte is discarded.
REQ-037 rst SHALL take priority over acceptance in the same cycle.

Structure
REQ-038 The shared package uart_pkg SHALL hold the state enum type (tx_state_t), a baud divisor function, and a DATA_BITS=8 constant.
REQ-039 The baud counter SHALL be a sub-module, uart_baud_gen (parameter BAUD_DIV; inputs clk, rst, clr; output tick one cycle per BAUD_DIV), reusable by the receive side.
REQ-040 No FIFO SHALL be included; buffering belongs to the surrounding stage.

Verification (CLK_FRQ=100, BAUD_RATE=10, BAUD_DIV=10 unless stated)
REQ-041 Send 0xA5, PARITY_EN=0 -> tx=0 for 10 cycles, then 1,0,1,0,0,1,0,1 each for 10 cycles, then 1 for 10 cycles; busy=1 for 100 cycles; done_tx pulses once.
REQ-042 Send 0x03, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2 -> parity bit 0; frame length 120 cycles; then send 0x07 with PARITY_ODD=1 -> parity bit 0.
REQ-043 Hold tx_valid high with 0x11 then 0x22 -> 0x22 accepted in the done_tx cycle of the first frame; the start bit follows 1 clk later; tx_data changes mid-frame do not alter bits.
REQ-044 Assert rst at cycle 35 of a frame carrying 0xFF -> tx=1 next cycle, busy=0, no done_tx pulse, tx_ready=1 one cycle after rst drops.
REQ-045 Loopback into the team receiver at equal parameters for 256 random bytes -> every received byte equals the sent byte, in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width, baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int baud_div(input int clk_frq, input int baud_rate);
    return clk_frq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in handshake plus serial line and status for the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic                 done_tx;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx, busy, done_tx
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx, busy, done_tx
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; tick marks the last cycle of each bit period.
module uart_baud_gen #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(BAUD_DIV - 1)) && !clr;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
    parameter int CLK_FRQ    = 100,
    parameter int BAUD_RATE  = 10,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic    clk,
    input logic    rst,
    uart_tx_if.slave bus
);
    import uart_pkg::*;

    localparam int BAUD_DIV = baud_div(CLK_FRQ, BAUD_RATE);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx: BAUD_DIV must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_EN != 0 && PARITY_EN != 1) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_flag
        $error("uart_tx: PARITY_EN and PARITY_ODD must be 0 or 1");
    end

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par_q, par_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;
    logic                 ready_q, ready_n;
    logic                 tick;
    logic                 accept;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign accept = bus.tx_valid && ready_q;

    // Parity is latched at acceptance because shreg is consumed as bits go out.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par_q;
        tx_n       = tx_q;
        done_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    shreg_n = bus.tx_data;
                    par_n   = (^bus.tx_data) ^ (PARITY_ODD == 1);
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = {1'b0, shreg[DATA_BITS-1:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_n    = IDLE;
                        stop_cnt_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                    tx_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
            ready_q  <= ready_n;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done_tx  = done_q;
    assign bus.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameter sets checked against a bit-level frame model.
module tb_uart_tx;

    localparam int DIV = 100 / 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int pen_c[3]  = '{0, 1, 1};
    int podd_c[3] = '{0, 0, 1};
    int sb_c[3]   = '{1, 2, 2};

    logic       valid_r[3];
    logic [7:0] data_r[3];
    logic       tx_w[3], busy_w[3], done_w[3], ready_w[3];

    uart_tx_if bus0();
    uart_tx_if bus1();
    uart_tx_if bus2();

    assign bus0.tx_valid = valid_r[0];
    assign bus0.tx_data  = data_r[0];
    assign bus1.tx_valid = valid_r[1];
    assign bus1.tx_data  = data_r[1];
    assign bus2.tx_valid = valid_r[2];
    assign bus2.tx_data  = data_r[2];

    assign tx_w[0] = bus0.tx;  assign busy_w[0] = bus0.busy;  assign done_w[0] = bus0.done_tx;  assign ready_w[0] = bus0.tx_ready;
    assign tx_w[1] = bus1.tx;  assign busy_w[1] = bus1.busy;  assign done_w[1] = bus1.done_tx;  assign ready_w[1] = bus1.tx_ready;
    assign tx_w[2] = bus2.tx;  assign busy_w[2] = bus2.busy;  assign done_w[2] = bus2.done_tx;  assign ready_w[2] = bus2.tx_ready;

    uart_tx #(.CLK_FRQ(100), .BAUD_RATE(10), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx #(.CLK_FRQ(100), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx #(.CLK_FRQ(100), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int n;
        n = 0;
        while (ready_w[sel] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (ready_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: tx_ready=%b after %0d cycles, required 1", tag, ready_w[sel], n);
        end
    endtask

    // Called in frame cycle 0 (one cycle after the accepting edge); returns in the done_tx cycle.
    task automatic run_frame(input int sel, input logic [7:0] b, input bit scramble, input string tag);
        logic       exp_bits[12];
        logic [7:0] rx;
        int         nbits;
        nbits = 1 + 8 + pen_c[sel] + sb_c[sel];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
        for (int i = 9; i < 12; i++) exp_bits[i] = 1'b1;
        if (pen_c[sel] == 1) exp_bits[9] = (($countones(b) + podd_c[sel]) % 2) == 1;
        rx = '0;
        for (int k = 0; k < nbits * DIV; k++) begin
            checks++;
            if (tx_w[sel] !== exp_bits[k / DIV]) begin
                errors++;
                $display("FAIL %s tx cycle %0d: got %b, required %b", tag, k, tx_w[sel], exp_bits[k / DIV]);
            end
            checks++;
            if (busy_w[sel] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b, required 1", tag, k, busy_w[sel]);
            end
            checks++;
            if (ready_w[sel] !== 1'b0) begin
                errors++;
                $display("FAIL %s tx_ready cycle %0d: got %b, required 0", tag, k, ready_w[sel]);
            end
            checks++;
            if (done_w[sel] !== 1'b0) begin
                errors++;
                $display("FAIL %s done_tx cycle %0d: got %b, required 0", tag, k, done_w[sel]);
            end
            if (k / DIV >= 1 && k / DIV <= 8 && k % DIV == DIV / 2) rx[k / DIV - 1] = tx_w[sel];
            if (scramble) data_r[sel] = 8'($urandom);
            step();
        end
        checks++;
        if (done_w[sel] !== 1'b1 || ready_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || tx_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_end: done=%b ready=%b busy=%b tx=%b, required 1 1 0 1",
                     tag, done_w[sel], ready_w[sel], busy_w[sel], tx_w[sel]);
        end
        checks++;
        if (rx !== b) begin
            errors++;
            $display("FAIL %s rx_byte: sampled %h, required %h", tag, rx, b);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] b, input string tag);
        wait_ready(sel, tag);
        valid_r[sel] = 1'b1;
        data_r[sel]  = b;
        step();
        valid_r[sel] = 1'b0;
        run_frame(sel, b, 1'b1, tag);
        step();
        checks++;
        if (done_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_single: done_tx=%b one cycle after pulse, required 0", tag, done_w[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (tx_w[s] !== 1'b1 || ready_w[s] !== 1'b0 || busy_w[s] !== 1'b0 || done_w[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: tx=%b ready=%b busy=%b done=%b, required 1 0 0 0",
                         s, tx_w[s], ready_w[s], busy_w[s], done_w[s]);
            end
        end
        rst = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ready_w[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release dut%0d: tx_ready=%b, required 1", s, ready_w[s]);
            end
        end
    endtask

    task automatic test_basic();
        send(0, 8'hA5, "basic_a5");
        send(1, 8'h03, "parity_even_03");
        send(2, 8'h07, "parity_odd_07");
        send(0, 8'h00, "basic_00");
        send(0, 8'hFF, "basic_ff");
    endtask

    task automatic test_back_to_back();
        wait_ready(0, "b2b");
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h11;
        step();
        data_r[0]  = 8'h22;
        run_frame(0, 8'h11, 1'b0, "b2b_first");
        step();
        valid_r[0] = 1'b0;
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: tx=%b busy=%b one cycle after done, required 0 1", tx_w[0], busy_w[0]);
        end
        run_frame(0, 8'h22, 1'b1, "b2b_second");
        step();
        checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done_w[0], busy_w[0]);
        end
    endtask

    task automatic test_mid_reset();
        bit saw_done;
        wait_ready(0, "mid_reset");
        valid_r[0] = 1'b1;
        data_r[0]  = 8'hFF;
        step();
        valid_r[0] = 1'b0;
        repeat (35) step();
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_busy_before: busy=%b, required 1", busy_w[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: tx=%b busy=%b done=%b ready=%b, required 1 0 0 0",
                     tx_w[0], busy_w[0], done_w[0], ready_w[0]);
        end
        step();
        checks++;
        if (ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: tx_ready=%b, required 1", ready_w[0]);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (done_w[0] === 1'b1 || tx_w[0] !== 1'b1) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: done pulse or line activity seen=%b, required 0", saw_done);
        end
        // Reset must win over a simultaneous acceptance.
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h5A;
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid_r[0] = 1'b0;
        step();
        checks++;
        if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority: busy=%b tx=%b, required 0 1", busy_w[0], tx_w[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            send(0, b, "rand_dut0");
        end
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send(1 + (i % 2), b, "rand_parity");
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            valid_r[s] = 1'b0;
            data_r[s]  = '0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
